// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared opcode constants, scheduler state encoding and instruction-class
// helpers for the decode-stage hazard controller.
package pipeline_hazard_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } hz_state_e;

   function automatic logic uses_rs1(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

   // Branches and JALR resolve in ID, so their operands must be final there.
   function automatic logic dec_branch(input logic [6:0] op);
      return (op == OP_BRANCH) || (op == OP_JALR);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
// Saturating event counter with an increment enable; only present in
// builds with HAZARD_PERF_CNT_EN defined.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller: stall/bubble, decode forwarding, gated redirect,
// and a memory-wait freeze with sticky timeout. Perf counters need HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [6:0]       id_opcode,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_RegWrite,
   input  logic             ex_MemRead,
   input  logic [4:0]       mem_rd,
   input  logic             mem_RegWrite,
   input  logic             mem_MemRead,
   input  logic             PCSrc_in,
   input  logic             dmem_busy,
   output logic             PCWrite,
   output logic             stall,
   output logic             freeze,
   output logic             PCSrc_out,
   output logic             flush,
   output logic             ForwardA_Dec,
   output logic             ForwardB_Dec,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] freeze_cnt,
   output logic [1:0]       fsm_state_o
);

   localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

   hz_state_e         state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              mem_timeout_q;

   logic use1, use2, br;
   logic m_ex_1, m_ex_2, m_mem_1, m_mem_2;
   logic ex_ld_hit, ex_alu_hit, mem_ld_hit, hz;

   assign use1 = uses_rs1(id_opcode);
   assign use2 = uses_rs2(id_opcode);
   assign br   = dec_branch(id_opcode);

   assign m_ex_1  = use1 && (id_rs1 != 5'd0) && ex_RegWrite  && (id_rs1 == ex_rd);
   assign m_ex_2  = use2 && (id_rs2 != 5'd0) && ex_RegWrite  && (id_rs2 == ex_rd);
   assign m_mem_1 = use1 && (id_rs1 != 5'd0) && mem_RegWrite && (id_rs1 == mem_rd);
   assign m_mem_2 = use2 && (id_rs2 != 5'd0) && mem_RegWrite && (id_rs2 == mem_rd);

   assign ex_ld_hit  =  ex_MemRead  && (m_ex_1  || m_ex_2);
   assign ex_alu_hit = !ex_MemRead  && (m_ex_1  || m_ex_2);
   assign mem_ld_hit =  mem_MemRead && (m_mem_1 || m_mem_2);
   assign hz         = ex_ld_hit || (br && (ex_alu_hit || mem_ld_hit));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= RUN;
         wcnt_q        <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wcnt_q        <= wcnt_d;
         mem_timeout_q <= (state_d == ERR);
      end
   end

   // wcnt_q counts busy cycles seen so far; the edge that would make it reach
   // MEM_TIMEOUT enters ERR instead of waiting any longer.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         RUN: begin
            if (dmem_busy) begin
               wcnt_d  = WCNT_W'(1);
               state_d = (MEM_TIMEOUT <= 1) ? ERR : WAIT;
            end
         end
         WAIT: begin
            if (!dmem_busy) begin
               state_d = RUN;
               wcnt_d  = '0;
            end else begin
               if (wcnt_q != WCNT_W'(MEM_TIMEOUT)) wcnt_d = wcnt_q + WCNT_W'(1);
               if (wcnt_q >= WCNT_W'(MEM_TIMEOUT - 1)) state_d = ERR;
            end
         end
         ERR:     state_d = ERR;
         default: state_d = RUN;
      endcase
   end

   // WAIT with busy already low behaves as RUN so the released pipeline
   // advances on this same cycle with full hazard and redirect checking.
   always_comb begin
      PCWrite      = 1'b0;
      stall        = 1'b0;
      freeze       = 1'b0;
      flush        = 1'b0;
      ForwardA_Dec = 1'b0;
      ForwardB_Dec = 1'b0;
      if (RESET) begin
         PCWrite = 1'b1;
         stall   = 1'b1;
         freeze  = 1'b1;
      end else if ((state_q == ERR) || dmem_busy) begin
         PCWrite = 1'b1;
         freeze  = 1'b1;
      end else begin
         PCWrite      = hz;
         stall        = hz;
         flush        = PCSrc_in && !hz;
         ForwardA_Dec = br && !mem_MemRead && m_mem_1 && !hz;
         ForwardB_Dec = br && !mem_MemRead && m_mem_2 && !hz;
      end
   end

   assign PCSrc_out   = flush;
   assign mem_timeout = mem_timeout_q;
   assign fsm_state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk_i (CLK),
      .rst_i (RESET),
      .inc_i (stall && !RESET),
      .cnt_o (stall_cnt)
   );

   hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk_i (CLK),
      .rst_i (RESET),
      .inc_i (flush),
      .cnt_o (flush_cnt)
   );

   hazard_perf_cnt #(.W(CNT_W)) u_freeze_cnt (
      .clk_i (CLK),
      .rst_i (RESET),
      .inc_i (freeze && !RESET),
      .cnt_o (freeze_cnt)
   );
`else
   assign stall_cnt  = '0;
   assign flush_cnt  = '0;
   assign freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a rule-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_pipeline_hazard_ctrl;
   import pipeline_hazard_ctrl_pkg::*;

   localparam int MEM_TIMEOUT = 16;
   localparam int CNT_W       = 32;

   logic             CLK = 1'b0;
   logic             RESET;
   logic [6:0]       id_opcode;
   logic [4:0]       id_rs1, id_rs2, ex_rd, mem_rd;
   logic             ex_RegWrite, ex_MemRead, mem_RegWrite, mem_MemRead;
   logic             PCSrc_in, dmem_busy;
   logic             PCWrite, stall, freeze, PCSrc_out, flush;
   logic             ForwardA_Dec, ForwardB_Dec, mem_timeout;
   logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
   logic [1:0]       fsm_state;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .id_opcode    (id_opcode),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .ex_rd        (ex_rd),
      .ex_RegWrite  (ex_RegWrite),
      .ex_MemRead   (ex_MemRead),
      .mem_rd       (mem_rd),
      .mem_RegWrite (mem_RegWrite),
      .mem_MemRead  (mem_MemRead),
      .PCSrc_in     (PCSrc_in),
      .dmem_busy    (dmem_busy),
      .PCWrite      (PCWrite),
      .stall        (stall),
      .freeze       (freeze),
      .PCSrc_out    (PCSrc_out),
      .flush        (flush),
      .ForwardA_Dec (ForwardA_Dec),
      .ForwardB_Dec (ForwardB_Dec),
      .mem_timeout  (mem_timeout),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt),
      .freeze_cnt   (freeze_cnt),
      .fsm_state_o  (fsm_state)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic pcwrite, stall, freeze, flush, fwd_a, fwd_b;
   } exp_t;

   int n_checks = 0;
   int n_errs   = 0;
   bit chk_en   = 1'b0;

   // model state: consecutive busy cycles, sticky error, event totals
   int busy_run     = 0;
   bit err_m        = 1'b0;
   int m_stall_cnt  = 0;
   int m_flush_cnt  = 0;
   int m_freeze_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs straight from the classification/priority rules.
   function automatic exp_t model();
      exp_t       e;
      logic [4:0] src [2];
      bit         used [2];
      bit         alu_mem [2];
      bit         br, ld_ex, alu_ex, ld_mem, hz;
      e = '0;
      src[0]  = id_rs1;
      src[1]  = id_rs2;
      used[0] = id_opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
      used[1] = id_opcode inside {OP_R, OP_STORE, OP_BRANCH};
      br      = id_opcode inside {OP_BRANCH, OP_JALR};
      ld_ex = 0; alu_ex = 0; ld_mem = 0; alu_mem[0] = 0; alu_mem[1] = 0;
      for (int i = 0; i < 2; i++) begin
         if (used[i] && src[i] != 5'd0) begin
            if (ex_RegWrite && src[i] == ex_rd) begin
               if (ex_MemRead) ld_ex = 1; else alu_ex = 1;
            end
            if (mem_RegWrite && src[i] == mem_rd) begin
               if (mem_MemRead) ld_mem = 1; else alu_mem[i] = 1;
            end
         end
      end
      hz = ld_ex || (br && (alu_ex || ld_mem));
      if (RESET) begin
         e.pcwrite = 1; e.stall = 1; e.freeze = 1;
      end else if (err_m || dmem_busy) begin
         e.pcwrite = 1; e.freeze = 1;
      end else begin
         e.stall   = hz;
         e.pcwrite = hz;
         e.flush   = PCSrc_in && !hz;
         e.fwd_a   = br && alu_mem[0] && !hz;
         e.fwd_b   = br && alu_mem[1] && !hz;
      end
      return e;
   endfunction

   always @(posedge CLK) begin
      exp_t e;
      e = model();
      if (RESET) begin
         busy_run = 0; err_m = 0;
         m_stall_cnt = 0; m_flush_cnt = 0; m_freeze_cnt = 0;
      end else begin
`ifdef HAZARD_PERF_CNT_EN
         if (e.stall)  m_stall_cnt++;
         if (e.flush)  m_flush_cnt++;
         if (e.freeze) m_freeze_cnt++;
`endif
         if (!err_m) begin
            if (dmem_busy) begin
               busy_run++;
               if (busy_run >= MEM_TIMEOUT) err_m = 1;
            end else begin
               busy_run = 0;
            end
         end
      end
   end

   // scoreboard compare, every cycle, on the inactive edge
   always @(negedge CLK) begin
      if (chk_en) begin
         exp_t e;
         e = model();
         check("PCWrite",      PCWrite,      e.pcwrite);
         check("stall",        stall,        e.stall);
         check("freeze",       freeze,       e.freeze);
         check("flush",        flush,        e.flush);
         check("PCSrc_out",    PCSrc_out,    e.flush);
         check("ForwardA_Dec", ForwardA_Dec, e.fwd_a);
         check("ForwardB_Dec", ForwardB_Dec, e.fwd_b);
         check("mem_timeout",  mem_timeout,  err_m);
         check("stall_cnt",    stall_cnt,    m_stall_cnt);
         check("flush_cnt",    flush_cnt,    m_flush_cnt);
         check("freeze_cnt",   freeze_cnt,   m_freeze_cnt);
      end
   end

   // driver tasks
   task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] erd, input logic erw, input logic emr,
                        input logic [4:0] mrd, input logic mrw, input logic mmr,
                        input logic pcsrc, input logic busy);
      id_opcode = op; id_rs1 = rs1; id_rs2 = rs2;
      ex_rd = erd; ex_RegWrite = erw; ex_MemRead = emr;
      mem_rd = mrd; mem_RegWrite = mrw; mem_MemRead = mmr;
      PCSrc_in = pcsrc; dmem_busy = busy;
      #2;
   endtask

   task automatic nop(input logic busy);
      drive(OP_I, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, busy);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET = 1'b1;
      drive(OP_BRANCH, 5'd1, 5'd2, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
      tick();
      chk_en = 1'b1;
      drive(OP_BRANCH, 5'd1, 5'd2, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
      check("rst_pcwrite", PCWrite, 1);
      check("rst_stall",   stall,   1);
      check("rst_freeze",  freeze,  1);
      check("rst_flush",   flush,   0);
      tick();
      RESET = 1'b0;
      nop(0); tick();

      // load-use: lw x5 in EX, add x6,x5,x1 in ID
      drive(OP_R, 5'd5, 5'd1, 5'd5, 1, 1, 5'd0, 0, 0, 0, 0);
      check("lu_stall", stall, 1);
      check("lu_pcw",   PCWrite, 1);
      check("lu_fwda",  ForwardA_Dec, 0);
      tick();
      drive(OP_R, 5'd5, 5'd1, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0);
      check("lu_stall2", stall, 0);
      check("lu_fwda2",  ForwardA_Dec, 0);
      tick();

      // load -> branch: beq x5,x0 with a redirect request throughout
      drive(OP_BRANCH, 5'd5, 5'd0, 5'd5, 1, 1, 5'd0, 0, 0, 1, 0);
      check("lb_stall1", stall, 1);
      check("lb_flush1", flush, 0);
      tick();
      drive(OP_BRANCH, 5'd5, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 1, 0);
      check("lb_stall2", stall, 1);
      check("lb_pcsrc2", PCSrc_out, 0);
      tick();
      drive(OP_BRANCH, 5'd5, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
      check("lb_stall3", stall, 0);
      check("lb_flush3", flush, 1);
      check("lb_pcsrc3", PCSrc_out, 1);
      tick();

      // ALU -> branch: addi x3 in EX, beq x3,x4; then forward from EX/MEM
      drive(OP_BRANCH, 5'd3, 5'd4, 5'd3, 1, 0, 5'd0, 0, 0, 0, 0);
      check("ab_stall", stall, 1);
      tick();
      drive(OP_BRANCH, 5'd3, 5'd4, 5'd0, 0, 0, 5'd3, 1, 0, 0, 0);
      check("ab_stall2", stall, 0);
      check("ab_fwda",   ForwardA_Dec, 1);
      tick();

      // bne x0,x7 with addi x7 in EX/MEM
      drive(OP_BRANCH, 5'd0, 5'd7, 5'd0, 0, 0, 5'd7, 1, 0, 0, 0);
      check("fb_fwdb",  ForwardB_Dec, 1);
      check("fb_fwda",  ForwardA_Dec, 0);
      check("fb_stall", stall, 0);
      tick();

      // x0 never matches: lw x0 then add x1,x0,x0
      drive(OP_R, 5'd0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0);
      check("x0_stall", stall, 0);
      tick();
      // store uses rs2, JAL uses nothing
      drive(OP_STORE, 5'd0, 5'd9, 5'd9, 1, 1, 5'd0, 0, 0, 0, 0);
      tick();
      drive(OP_JAL, 5'd9, 5'd9, 5'd9, 1, 1, 5'd9, 1, 1, 1, 0);
      tick();
      nop(0); tick();

      // 5-cycle memory wait with a pending load-use hazard
      for (int i = 1; i <= 5; i++) begin
         drive(OP_R, 5'd5, 5'd1, 5'd5, 1, 1, 5'd0, 0, 0, 1, 1);
         if (i == 1) begin
            check("bz_freeze1", freeze, 1);
            check("bz_stall1",  stall, 0);
         end
         tick();
      end
      nop(0);
      check("bz_freeze6", freeze, 0);
      check("bz_mt6",     mem_timeout, 0);
`ifdef HAZARD_PERF_CNT_EN
      check("bz_fcnt", freeze_cnt, 5);
`endif
      tick();
      nop(0); tick();

      // 20-cycle wait overruns the timeout
      for (int i = 1; i <= 20; i++) begin
         nop(1);
         if (i == 16) check("to_mt16", mem_timeout, 0);
         if (i == 17) check("to_mt17", mem_timeout, 1);
         tick();
      end
      drive(OP_I, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
      check("to_sticky", mem_timeout, 1);
      check("to_freeze", freeze, 1);
      check("to_flush",  flush, 0);
      tick();
      RESET = 1'b1;
      nop(0);
      check("to_rst_mt", mem_timeout, 1);
      tick();
      RESET = 1'b0;
      nop(0);
      check("to_clr_mt",  mem_timeout, 0);
      check("to_clr_frz", freeze, 0);
      tick();
      nop(0); tick();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
